// File: rtl/pong_input_conditioner.sv
// pong_input_conditioner: synchronizes and debounces the start button and two quadrature
// encoders, producing single-cycle events and saturating paddle positions.
module pong_input_conditioner #(
  parameter int DB_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int PADDLE_MAX      = 12,
  parameter int PADDLE_INIT     = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_in,
  input  logic       p1_a,
  input  logic       p1_b,
  input  logic       p2_a,
  input  logic       p2_b,
  output logic       start_pulse,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p1_err,
  output logic       p2_err,
  output logic [3:0] p1_pos,
  output logic [3:0] p2_pos
);
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PMAX  = 4'(PADDLE_MAX);
  localparam logic [3:0] PINIT = 4'(PADDLE_INIT);
  logic [4:0] raw, filt, filt_q;
  logic [2:0] e1, e2;
  logic       st;
  assign raw = {p2_b, p2_a, p1_b, p1_a, start_in};
  for (genvar i = 0; i < 5; i++) begin : g_ch
    logic s1, s2, f;
    logic [DB_WIDTH-1:0] c;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        f  <= 1'b0;
        c  <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == f) c <= '0;
        else if (c == DB_LAST) begin
          f <= s2;
          c <= '0;
        end else c <= c + 1'b1;
      end
    assign filt[i] = f;
  end
  // returns {up, down, err} for a gray-code step prev -> cur
  function automatic logic [2:0] decode(input logic [1:0] p, input logic [1:0] c);
    logic [3:0] t;
    t = {p, c};
    decode = {t == 4'b0001 || t == 4'b0111 || t == 4'b1110 || t == 4'b1000,
              t == 4'b0010 || t == 4'b1011 || t == 4'b1101 || t == 4'b0100,
              (p ^ c) == 2'b11};
  endfunction
  function automatic logic [3:0] next_pos(input logic [3:0] p, input logic [2:0] e, input logic s);
    next_pos = s ? PINIT : (e[2] && p < PMAX) ? p + 4'd1 : (e[1] && p != 4'd0) ? p - 4'd1 : p;
  endfunction
  assign st = filt[0] & ~filt_q[0];
  assign e1 = decode({filt_q[1], filt_q[2]}, {filt[1], filt[2]});
  assign e2 = decode({filt_q[3], filt_q[4]}, {filt[3], filt[4]});
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      filt_q      <= '0;
      start_pulse <= 1'b0;
      {p1_up, p1_down, p1_err} <= 3'b000;
      {p2_up, p2_down, p2_err} <= 3'b000;
      p1_pos      <= PINIT;
      p2_pos      <= PINIT;
    end else begin
      filt_q      <= filt;
      start_pulse <= st;
      {p1_up, p1_down, p1_err} <= e1;
      {p2_up, p2_down, p2_err} <= e2;
      p1_pos      <= next_pos(p1_pos, e1, st);
      p2_pos      <= next_pos(p2_pos, e2, st);
    end
endmodule

// File: tb/tb_pong_input_conditioner.sv
// tb_pong_input_conditioner: directed self-checking bench with DEBOUNCE_CYCLES = 4.
module tb_pong_input_conditioner;
  localparam int D = 4;
  logic clk = 1'b0, reset_n = 1'b1;
  logic start_in = 1'b0, p1_a = 1'b0, p1_b = 1'b0, p2_a = 1'b0, p2_b = 1'b0;
  logic start_pulse, p1_up, p1_down, p2_up, p2_down, p1_err, p2_err;
  logic [3:0] p1_pos, p2_pos;
  int checks = 0, fails = 0;
  int n_st = 0, n_u1 = 0, n_d1 = 0, n_e1 = 0, n_u2 = 0, n_d2 = 0, n_e2 = 0;

  pong_input_conditioner #(.DB_WIDTH(8), .DEBOUNCE_CYCLES(D), .PADDLE_MAX(12), .PADDLE_INIT(6)) dut (
    .clk(clk), .reset_n(reset_n), .start_in(start_in),
    .p1_a(p1_a), .p1_b(p1_b), .p2_a(p2_a), .p2_b(p2_b),
    .start_pulse(start_pulse), .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down), .p1_err(p1_err), .p2_err(p2_err),
    .p1_pos(p1_pos), .p2_pos(p2_pos));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_st += int'(start_pulse);
    n_u1 += int'(p1_up);
    n_d1 += int'(p1_down);
    n_e1 += int'(p1_err);
    n_u2 += int'(p2_up);
    n_d2 += int'(p2_down);
    n_e2 += int'(p2_err);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] nxt(input logic up, input logic [1:0] s);
    nxt = up ? (s == 2'b00 ? 2'b01 : s == 2'b01 ? 2'b11 : s == 2'b11 ? 2'b10 : 2'b00)
             : (s == 2'b00 ? 2'b10 : s == 2'b10 ? 2'b11 : s == 2'b11 ? 2'b01 : 2'b00);
  endfunction

  task automatic test_reset;
    logic [6:0] pl;
    #1 reset_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      {start_in, p1_a, p1_b, p2_a, p2_b} = 5'($urandom);
      tick(1);
      pl = {start_pulse, p1_up, p1_down, p1_err, p2_up, p2_down, p2_err};
      checks++;
      if (pl !== 7'b0 || p1_pos !== 4'd6 || p2_pos !== 4'd6) begin
        fails++;
        $display("FAIL reset_hold: pulses=%b p1_pos=%0d p2_pos=%0d, want 0000000/6/6", pl, p1_pos, p2_pos);
      end
    end
    {start_in, p1_a, p1_b, p2_a, p2_b} = 5'b0;
    tick(1);
    reset_n = 1'b1;
    for (int k = 0; k < D + 1; k++) begin
      tick(1);
      pl = {start_pulse, p1_up, p1_down, p1_err, p2_up, p2_down, p2_err};
      checks++;
      if (pl !== 7'b0 || p1_pos !== 4'd6 || p2_pos !== 4'd6) begin
        fails++;
        $display("FAIL reset_release: pulses=%b p1_pos=%0d p2_pos=%0d, want 0000000/6/6", pl, p1_pos, p2_pos);
      end
    end
  endtask

  task automatic test_glitch;
    int b;
    b = n_st;
    start_in = 1'b1;
    tick(3);
    start_in = 1'b0;
    tick(15);
    checks++;
    if (n_st - b !== 0) begin
      fails++;
      $display("FAIL glitch_reject: start pulses=%0d, want 0", n_st - b);
    end
    b = n_st;
    start_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (k == 5) start_in = 1'b0;
      checks++;
      if (start_pulse !== (k == 6)) begin
        fails++;
        $display("FAIL start_latency: edge %0d start_pulse=%b, want %b", k, start_pulse, k == 6);
      end
    end
    tick(15);
    checks++;
    if (n_st - b !== 1) begin
      fails++;
      $display("FAIL start_count: start pulses=%0d, want 1", n_st - b);
    end
  endtask

  task automatic test_up;
    int bu, bd, be;
    logic [1:0] s;
    bu = n_u1; bd = n_d1; be = n_e1; s = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      s = nxt(1'b1, s);
      {p1_a, p1_b} = s;
      tick(10);
      checks++;
      if (p1_pos !== 4'(6 + i)) begin
        fails++;
        $display("FAIL up_pos: step %0d p1_pos=%0d, want %0d", i, p1_pos, 6 + i);
      end
    end
    checks++;
    if (n_u1 - bu !== 4 || n_d1 - bd !== 0 || n_e1 - be !== 0) begin
      fails++;
      $display("FAIL up_counts: up=%0d down=%0d err=%0d, want 4/0/0", n_u1 - bu, n_d1 - bd, n_e1 - be);
    end
  endtask

  task automatic test_saturation;
    int bu, bd, be, ex;
    logic [1:0] s;
    bu = n_u2; bd = n_d2; be = n_e2; s = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      s = nxt(1'b0, s);
      {p2_a, p2_b} = s;
      tick(10);
      ex = (6 - i < 0) ? 0 : 6 - i;
      checks++;
      if (p2_pos !== 4'(ex)) begin
        fails++;
        $display("FAIL sat_down_pos: step %0d p2_pos=%0d, want %0d", i, p2_pos, ex);
      end
    end
    checks++;
    if (n_d2 - bd !== 20 || n_u2 - bu !== 0 || n_e2 - be !== 0) begin
      fails++;
      $display("FAIL sat_down_counts: down=%0d up=%0d err=%0d, want 20/0/0", n_d2 - bd, n_u2 - bu, n_e2 - be);
    end
    bu = n_u2;
    for (int i = 1; i <= 15; i++) begin
      s = nxt(1'b1, s);
      {p2_a, p2_b} = s;
      tick(10);
      ex = (i > 12) ? 12 : i;
      checks++;
      if (p2_pos !== 4'(ex)) begin
        fails++;
        $display("FAIL sat_up_pos: step %0d p2_pos=%0d, want %0d", i, p2_pos, ex);
      end
    end
    checks++;
    if (n_u2 - bu !== 15) begin
      fails++;
      $display("FAIL sat_up_count: up=%0d, want 15", n_u2 - bu);
    end
  endtask

  task automatic test_illegal;
    int bu, bd, be;
    bu = n_u1; bd = n_d1; be = n_e1;
    {p1_a, p1_b} = 2'b11;
    tick(10);
    checks++;
    if (n_e1 - be !== 1 || n_u1 - bu !== 0 || n_d1 - bd !== 0 || p1_pos !== 4'd10) begin
      fails++;
      $display("FAIL illegal_00_11: err=%0d up=%0d down=%0d pos=%0d, want 1/0/0/10", n_e1 - be, n_u1 - bu, n_d1 - bd, p1_pos);
    end
    {p1_a, p1_b} = 2'b00;
    tick(10);
    checks++;
    if (n_e1 - be !== 2 || n_u1 - bu !== 0 || n_d1 - bd !== 0 || p1_pos !== 4'd10) begin
      fails++;
      $display("FAIL illegal_11_00: err=%0d up=%0d down=%0d pos=%0d, want 2/0/0/10", n_e1 - be, n_u1 - bu, n_d1 - bd, p1_pos);
    end
  endtask

  task automatic test_priority;
    start_in = 1'b1;
    p1_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (k == 5) begin
        checks++;
        if (p1_pos !== 4'd10 || start_pulse !== 1'b0) begin
          fails++;
          $display("FAIL priority_before: p1_pos=%0d start_pulse=%b, want 10/0", p1_pos, start_pulse);
        end
      end
      if (k == 6) begin
        checks++;
        if (start_pulse !== 1'b1 || p1_up !== 1'b1 || p1_pos !== 4'd6 || p2_pos !== 4'd6) begin
          fails++;
          $display("FAIL priority: start=%b p1_up=%b p1_pos=%0d p2_pos=%0d, want 1/1/6/6", start_pulse, p1_up, p1_pos, p2_pos);
        end
      end
    end
    start_in = 1'b0;
    tick(15);
    checks++;
    if (p1_pos !== 4'd6 || start_pulse !== 1'b0) begin
      fails++;
      $display("FAIL priority_after: p1_pos=%0d start_pulse=%b, want 6/0", p1_pos, start_pulse);
    end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_up;
    test_saturation;
    test_illegal;
    test_priority;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
